rs_dispatch_scheduler: RTL and testbench

In-order dispatch scheduler between rename/decode and the three single-entry reservation stations (ALU tags 00/01/10). It buffers up to three decoded instructions per cycle in a circular queue. Each cycle it steers the oldest queued instructions to whichever reservation stations report `dispatch_ready`, so the oldest pending instruction always takes the lowest-index free station. The lane index a payload leaves on is its ALU tag for downstream dependency tracking.

---
 rtl/rs_dispatch_scheduler_pkg.sv | 33 +++
 rtl/rs_dispatch_scheduler_if.sv | 25 ++
 rtl/rs_dispatch_scheduler_ready_select_3.sv | 27 ++
 rtl/rs_dispatch_scheduler.sv | 111 +++++++++++
 tb/tb_rs_dispatch_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared dispatch definitions: station tags, decode-to-RS payload packing, small helpers.
// Decode, the scheduler and the reservation stations all import this package.
package dispatch_pkg;

    localparam int NUM_RS = 3;

    typedef enum logic [1:0] {
        TAG_ALU0  = 2'b00,
        TAG_ALU1  = 2'b01,
        TAG_ALU2  = 2'b10,
        TAG_READY = 2'b11
    } rs_tag_e;

    // Decode-to-RS field packing; the scheduler itself treats the payload as opaque bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [19:0] ctrl;
        logic [6:0]  rs1_phys_addr;
        logic [6:0]  rs2_phys_addr;
        logic [6:0]  rd_phys_addr;
        logic [3:0]  br_tag;
        logic        br_pred_taken;
        logic [17:0] br_offset;
    } payload_t;

    localparam int PAYLOAD_BITS = $bits(payload_t);

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/rs_dispatch_scheduler_if.sv
// Rename-side input group and reservation-station dispatch bus of the dispatch scheduler.
// master: rename plus reservation stations; slave: the scheduler.
interface rs_dispatch_scheduler_if #(
    parameter int PAYLOAD_WIDTH = 128
);
    import dispatch_pkg::*;

    logic [NUM_RS-1:0]               in_valid;
    logic [NUM_RS*PAYLOAD_WIDTH-1:0] in_payload;
    logic                            in_ready;
    logic [NUM_RS-1:0]               rs_dispatch_valid;
    logic [NUM_RS*PAYLOAD_WIDTH-1:0] rs_dispatch_payload;
    logic [NUM_RS-1:0]               rs_dispatch_ready;

    modport master (
        output in_valid, in_payload, rs_dispatch_ready,
        input  in_ready, rs_dispatch_valid, rs_dispatch_payload
    );

    modport slave (
        input  in_valid, in_payload, rs_dispatch_ready,
        output in_ready, rs_dispatch_valid, rs_dispatch_payload
    );

endinterface

// File: rtl/rs_dispatch_scheduler_ready_select_3.sv
// Maps an age index m and a station ready mask to the one-hot select of the m-th
// ready station (scanning from bit 0), and reports how many stations are ready.
module ready_select_3
    import dispatch_pkg::*;
(
    input  logic [1:0]        i_age,
    input  logic [NUM_RS-1:0] i_ready,
    output logic [NUM_RS-1:0] o_sel,
    output logic [1:0]        o_ready_cnt
);

    logic [1:0] w_cnt;

    always_comb begin
        o_sel = '0;
        w_cnt = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (i_ready[i]) begin
                if (w_cnt == i_age) o_sel[i] = 1'b1;
                w_cnt = w_cnt + 2'd1;
            end
        end
    end

    assign o_ready_cnt = w_cnt;

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// In-order dispatch scheduler: circular queue fed by up to three renamed instructions per
// cycle, draining oldest-first onto the lowest-index free reservation stations.
module rs_dispatch_scheduler #(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int DEPTH         = 8,
    parameter int NUM_RS        = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    rs_dispatch_scheduler_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic [15:0]                  stall_cycles
);
    import dispatch_pkg::*;

    localparam int PW = PAYLOAD_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]        r_mem [DEPTH];
    logic [AW-1:0]        r_head;
    logic [AW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [15:0]          r_stall;

    logic [CW:0]          w_free;
    logic                 w_in_ready;
    logic                 w_push;
    logic [1:0]           w_push_n;
    logic [1:0]           w_k;
    logic [NUM_RS-1:0]    w_sel [NUM_RS];
    logic [1:0]           w_r   [NUM_RS];
    logic [NUM_RS-1:0]    w_valid;
    logic [NUM_RS*PW-1:0] w_payload;

    // Accept decision uses only registered occupancy, never same-cycle pops.
    assign w_free     = (CW+1)'(DEPTH) - {1'b0, r_count};
    assign w_in_ready = w_free >= (CW+1)'(3);
    assign w_push_n   = popcount3(bus.in_valid);
    assign w_push     = (bus.in_valid != '0) && w_in_ready && !flush;

    for (genvar m = 0; m < NUM_RS; m++) begin : g_age
        ready_select_3 u_sel (
            .i_age       (2'(m)),
            .i_ready     (bus.rs_dispatch_ready),
            .o_sel       (w_sel[m]),
            .o_ready_cnt (w_r[m])
        );
    end

    always_comb begin
        w_valid   = '0;
        w_payload = '0;
        if (!flush) begin
            for (int unsigned m = 0; m < NUM_RS; m++) begin
                if ((CW'(m) < r_count) && (2'(m) < w_r[m])) begin
                    for (int unsigned i = 0; i < NUM_RS; i++) begin
                        if (w_sel[m][i]) begin
                            w_valid[i]             = 1'b1;
                            w_payload[i*PW +: PW]  = r_mem[r_head + AW'(m)];
                        end
                    end
                end
            end
        end
    end

    assign w_k                     = popcount3(w_valid);
    assign bus.in_ready            = w_in_ready;
    assign bus.rs_dispatch_valid   = w_valid;
    assign bus.rs_dispatch_payload = w_payload;
    assign queue_count             = r_count;
    assign stall_cycles            = r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_stall <= '0;
        end else begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + AW'(w_k);
                if (w_push) r_tail <= r_tail + AW'(w_push_n);
                r_count <= r_count + (w_push ? CW'(w_push_n) : CW'(0)) - CW'(w_k);
            end
            if ((r_count != '0) && (bus.rs_dispatch_ready == '0) && !flush &&
                (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    // Payload storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            for (int unsigned j = 0; j < NUM_RS; j++) begin
                if (bus.in_valid[j]) r_mem[r_tail + AW'(j)] <= bus.in_payload[j*PW +: PW];
            end
        end
    end

    a_in_valid_contig: assert property (@(posedge clk) disable iff (reset)
        !(bus.in_valid[1] && !bus.in_valid[0]) && !(bus.in_valid[2] && !bus.in_valid[1]));

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Bench for rs_dispatch_scheduler: directed vector table, wrap/order sequence, and random
// stimulus checked against a queue-based reference model.
module tb_rs_dispatch_scheduler;
    import dispatch_pkg::*;

    localparam int PW    = 128;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [3:0]  queue_count;
    logic [15:0] stall_cycles;

    rs_dispatch_scheduler_if #(.PAYLOAD_WIDTH(PW)) u_if ();

    rs_dispatch_scheduler #(
        .PAYLOAD_WIDTH (PW),
        .DEPTH         (DEPTH),
        .NUM_RS        (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (u_if),
        .queue_count  (queue_count),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] mq [$];
    logic [15:0]   m_stall;
    logic          c_rst, c_fl;
    logic [2:0]    c_iv, c_rdy;
    logic [PW-1:0] c_pay [3];

    typedef struct {
        logic        rst;
        logic        fl;
        logic [2:0]  iv;
        logic [31:0] base;
        logic [2:0]  rdy;
        logic [2:0]  e_valid;
        logic [31:0] e_id0;
        logic [31:0] e_id1;
        logic [31:0] e_id2;
        int          e_cnt;
        logic        e_inrdy;
        int          e_stall;
    } vec_t;

    vec_t tv [21];

    function automatic logic [PW-1:0] pay(input logic [31:0] id);
        return {id, id, id, id};
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [2:0] iv,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                         input logic [PW-1:0] p2, input logic [2:0] rdy);
        @(negedge clk);
        reset                 = rst;
        flush                 = fl;
        u_if.in_valid         = iv;
        u_if.in_payload       = {p2, p1, p0};
        u_if.rs_dispatch_ready = rdy;
        c_rst = rst; c_fl = fl; c_iv = iv; c_rdy = rdy;
        c_pay[0] = p0; c_pay[1] = p1; c_pay[2] = p2;
        #1;
    endtask

    // Oldest queued entries go to ready stations in ascending index order.
    task automatic check_model();
        logic [2:0]      ev;
        logic [3*PW-1:0] ep;
        int              k, m;
        ev = '0; ep = '0; m = 0;
        k  = (mq.size() < $countones(c_rdy)) ? mq.size() : $countones(c_rdy);
        if (!c_fl) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (c_rdy[i] && m < k) begin
                    ev[i] = 1'b1;
                    ep[i*PW +: PW] = mq[m];
                    m++;
                end
            end
        end
        chk("valid", u_if.rs_dispatch_valid, ev);
        for (int i = 0; i < NUM_RS; i++)
            chk($sformatf("payload%0d", i), u_if.rs_dispatch_payload[i*PW +: PW], ep[i*PW +: PW]);
        chk("in_ready", u_if.in_ready, (DEPTH - mq.size()) >= 3);
        chk("queue_count", queue_count, mq.size());
        chk("stall_cycles", stall_cycles, m_stall);
    endtask

    task automatic advance();
        int sz, k;
        sz = mq.size();
        k  = (sz < $countones(c_rdy)) ? sz : $countones(c_rdy);
        @(posedge clk);
        if (c_rst) begin
            mq.delete();
            m_stall = '0;
        end else if (c_fl) begin
            mq.delete();
        end else begin
            if (sz != 0 && c_rdy == 3'b000 && m_stall != 16'hFFFF) m_stall++;
            repeat (k) void'(mq.pop_front());
            if (c_iv != 3'b000 && (DEPTH - sz) >= 3)
                for (int j = 0; j < NUM_RS; j++) if (c_iv[j]) mq.push_back(c_pay[j]);
        end
    endtask

    function automatic logic [2:0] lanes(input int n);
        return (n == 1) ? 3'b001 : (n == 2) ? 3'b011 : (n == 3) ? 3'b111 : 3'b000;
    endfunction

    int next_id;
    int seq_id;

    task automatic wrap_step(input int n, input logic [2:0] rdy);
        drive(1'b0, 1'b0, lanes(n), pay(seq_id), pay(seq_id + 1), pay(seq_id + 2), rdy);
        check_model();
        for (int i = 0; i < NUM_RS; i++) begin
            if (u_if.rs_dispatch_valid[i]) begin
                chk("order", u_if.rs_dispatch_payload[i*PW +: PW], pay(next_id));
                next_id++;
            end
        end
        if (n > 0 && u_if.in_ready) seq_id += n;
        advance();
    endtask

    int grp [10] = '{1, 2, 3, 2, 1, 3, 3, 1, 2, 2};

    initial begin
        tv[0]  = '{0, 0, 3'b111, 'h10, 3'b111, 3'b000, 0,     0,     0,     0, 1, 0};
        tv[1]  = '{0, 0, 3'b000, 0,    3'b111, 3'b111, 'h10,  'h11,  'h12,  3, 1, 0};
        tv[2]  = '{0, 0, 3'b111, 'h20, 3'b000, 3'b000, 0,     0,     0,     0, 1, 0};
        tv[3]  = '{0, 0, 3'b000, 0,    3'b101, 3'b101, 'h20,  0,     'h21,  3, 1, 0};
        tv[4]  = '{0, 0, 3'b000, 0,    3'b010, 3'b010, 0,     'h22,  0,     1, 1, 0};
        tv[5]  = '{0, 0, 3'b000, 0,    3'b000, 3'b000, 0,     0,     0,     0, 1, 0};
        tv[6]  = '{0, 0, 3'b111, 'h30, 3'b000, 3'b000, 0,     0,     0,     0, 1, 0};
        tv[7]  = '{0, 0, 3'b111, 'h40, 3'b000, 3'b000, 0,     0,     0,     3, 1, 0};
        tv[8]  = '{0, 0, 3'b111, 'h50, 3'b000, 3'b000, 0,     0,     0,     6, 0, 1};
        tv[9]  = '{0, 0, 3'b111, 'h60, 3'b111, 3'b111, 'h30,  'h31,  'h32,  6, 0, 2};
        tv[10] = '{0, 0, 3'b000, 0,    3'b000, 3'b000, 0,     0,     0,     3, 1, 2};
        tv[11] = '{0, 0, 3'b011, 'h70, 3'b000, 3'b000, 0,     0,     0,     3, 1, 3};
        tv[12] = '{0, 1, 3'b111, 'h80, 3'b111, 3'b000, 0,     0,     0,     5, 1, 4};
        tv[13] = '{0, 0, 3'b000, 0,    3'b111, 3'b000, 0,     0,     0,     0, 1, 4};
        tv[14] = '{0, 0, 3'b111, 'h90, 3'b000, 3'b000, 0,     0,     0,     0, 1, 4};
        tv[15] = '{0, 0, 3'b001, 'hA0, 3'b000, 3'b000, 0,     0,     0,     3, 1, 4};
        tv[16] = '{1, 0, 3'b000, 0,    3'b000, 3'b000, 0,     0,     0,     4, 1, 5};
        tv[17] = '{0, 0, 3'b111, 'hB0, 3'b111, 3'b000, 0,     0,     0,     0, 1, 0};
        tv[18] = '{0, 0, 3'b000, 0,    3'b011, 3'b011, 'hB0,  'hB1,  0,     3, 1, 0};
        tv[19] = '{0, 0, 3'b000, 0,    3'b100, 3'b100, 0,     0,     'hB2,  1, 1, 0};
        tv[20] = '{0, 0, 3'b000, 0,    3'b111, 3'b000, 0,     0,     0,     0, 1, 0};

        m_stall = '0;
        repeat (2) begin
            drive(1'b1, 1'b0, 3'b000, '0, '0, '0, 3'b000);
            advance();
        end

        foreach (tv[r]) begin
            drive(tv[r].rst, tv[r].fl, tv[r].iv, pay(tv[r].base), pay(tv[r].base + 1),
                  pay(tv[r].base + 2), tv[r].rdy);
            chk($sformatf("t%0d_valid", r), u_if.rs_dispatch_valid, tv[r].e_valid);
            chk($sformatf("t%0d_count", r), queue_count, tv[r].e_cnt);
            chk($sformatf("t%0d_in_ready", r), u_if.in_ready, tv[r].e_inrdy);
            chk($sformatf("t%0d_stall", r), stall_cycles, tv[r].e_stall);
            chk($sformatf("t%0d_rs0", r), u_if.rs_dispatch_payload[0*PW +: PW],
                tv[r].e_valid[0] ? pay(tv[r].e_id0) : '0);
            chk($sformatf("t%0d_rs1", r), u_if.rs_dispatch_payload[1*PW +: PW],
                tv[r].e_valid[1] ? pay(tv[r].e_id1) : '0);
            chk($sformatf("t%0d_rs2", r), u_if.rs_dispatch_payload[2*PW +: PW],
                tv[r].e_valid[2] ? pay(tv[r].e_id2) : '0);
            check_model();
            advance();
        end

        next_id = 'h1000;
        seq_id  = 'h1000;
        for (int r = 0; r < 5; r++) begin
            wrap_step(grp[2*r], 3'b000);
            wrap_step(grp[2*r+1], 3'($urandom_range(0, 7)));
            for (int c = 0; c < 8 && mq.size() != 0; c++)
                wrap_step(0, 3'($urandom_range(1, 7)));
        end
        chk("order_drained", next_id, seq_id);

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  lanes($urandom_range(0, 3)),
                  {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7)));
            check_model();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
